grain_median3x3: RTL and testbench

- Streaming 3x3 median filter that removes isolated grain/salt-pepper pixels.
- Sits directly downstream of the ROM-read/2x2-averaging image stage and consumes its data_valid/data_out pixel stream in raster order.
- Buffers two image rows internally and emits one median pixel per interior window.
- Has no backpressure; it must accept a pixel on every cycle that in_valid is high.

---
 rtl/grain_median3x3.sv | 172 +++++++++++++++++
 tb/tb_grain_median3x3.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grain_median3x3.sv
// Streaming 3x3 median filter: two line buffers feed a sliding 3x3 window,
// and a 3-stage compare network emits one median per interior pixel.
module grain_median3x3 #(
    parameter int IMG_W = 223,
    parameter int IMG_H = 223,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [7:0]    out_row,
    output logic [7:0]    out_col,
    output logic          frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          at_origin;
    logic          flush;
    logic          win_done;

    logic [DW-1:0] linebuf1 [IMG_W];
    logic [DW-1:0] linebuf2 [IMG_W];
    logic [DW-1:0] lb1_rd;
    logic [DW-1:0] lb2_rd;

    // win[row][col]: row 0 is the oldest line (r-2), col 2 is the newest column
    logic [DW-1:0] win [3][3];
    logic          win_valid;
    logic [7:0]    win_row;
    logic [7:0]    win_col;

    logic [DW-1:0] s1_lo  [3];
    logic [DW-1:0] s1_mid [3];
    logic [DW-1:0] s1_hi  [3];
    logic          s1_valid;
    logic [7:0]    s1_row;
    logic [7:0]    s1_col;

    logic [DW-1:0] s2_a;
    logic [DW-1:0] s2_b;
    logic [DW-1:0] s2_c;
    logic          s2_valid;
    logic [7:0]    s2_row;
    logic [7:0]    s2_col;

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] max3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // A start-of-frame arriving exactly at (0,0) is the natural start of a
    // back-to-back frame, so it must not kill the previous frame's tail.
    always_comb begin
        at_origin = (col_cnt == '0) && (row_cnt == '0);
        flush     = in_valid && in_sof && !at_origin;
        cur_col   = in_sof ? '0 : col_cnt;
        cur_row   = in_sof ? '0 : row_cnt;
        win_done  = in_valid && !in_sof && (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
        lb1_rd    = linebuf1[cur_col];
        lb2_rd    = linebuf2[cur_col];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (in_valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt <= cur_col + 1'b1;
                row_cnt <= cur_row;
            end
        end
    end

    // Storage needs no reset: rows 0 and 1 of every frame rewrite it before use
    always_ff @(posedge clk) begin
        if (in_valid) begin
            linebuf1[cur_col] <= in_data;
            linebuf2[cur_col] <= lb1_rd;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            win_valid <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            win_valid <= win_done;
            s1_valid  <= win_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        win_row <= 8'(row_cnt) - 8'd1;
        win_col <= 8'(col_cnt) - 8'd1;
        s1_row  <= win_row;
        s1_col  <= win_col;
        s2_row  <= s1_row;
        s2_col  <= s1_col;
        for (int k = 0; k < 3; k++) begin
            s1_lo[k]  <= min3(win[0][k], win[1][k], win[2][k]);
            s1_mid[k] <= med3(win[0][k], win[1][k], win[2][k]);
            s1_hi[k]  <= max3(win[0][k], win[1][k], win[2][k]);
        end
        s2_a <= max3(s1_lo[0], s1_lo[1], s1_lo[2]);
        s2_b <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
        s2_c <= min3(s1_hi[0], s1_hi[1], s1_hi[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else if (s2_valid) begin
            out_data <= med3(s2_a, s2_b, s2_c);
            out_row  <= s2_row;
            out_col  <= s2_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && (out_row == 8'(IMG_H - 2)) && (out_col == 8'(IMG_W - 2));
        end
    end

endmodule

// File: tb/tb_grain_median3x3.sv
// Randomised scoreboard bench for grain_median3x3 on a 5x4 image; the
// reference computes each window median by sorting its nine pixels.
module tb_grain_median3x3;

    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int DW    = 8;
    localparam int FULL_FRAMES = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_row;
    logic [7:0]    out_col;
    logic          frame_done;

    typedef struct {
        logic [7:0] data;
        logic [7:0] row;
        logic [7:0] col;
        int         cyc;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] img [IMG_H][IMG_W];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cyc = -1;
    int fd_seen = 0;
    int mr = 0;
    int mc = 0;

    grain_median3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_sof(in_sof),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_row(out_row),
        .out_col(out_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] genPix(int kind, int r, int c);
        case (kind)
            0:       return 8'd100;
            1:       return (r == 1 && c == 2) ? 8'd255 : 8'd0;
            2:       return 8'(10 * c);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [7:0] median9(int r, int c);
        logic [7:0] v [9];
        logic [7:0] t;
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                v[n] = img[r + dr][c + dc];
                n++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j + 1]) begin
                    t = v[j];
                    v[j] = v[j + 1];
                    v[j + 1] = t;
                end
            end
        end
        return v[4];
    endfunction

    // One input beat; the expected window result is queued once the beat is taken
    task automatic applyStimulus(int kind, bit sof, int gap);
        int pr;
        int pc;
        logic [7:0] pix;
        exp_t e;
        pr = sof ? 0 : mr;
        pc = sof ? 0 : mc;
        pix = genPix(kind, pr, pc);
        in_valid = 1'b1;
        in_sof = sof;
        in_data = pix;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        if (sof && (mr != 0 || mc != 0)) exp_q.delete();
        img[pr][pc] = pix;
        if (pr >= 2 && pc >= 2) begin
            e.data = median9(pr - 1, pc - 1);
            e.row = 8'(pr - 1);
            e.col = 8'(pc - 1);
            e.cyc = cyc + 3;
            e.last = (pr == IMG_H - 1) && (pc == IMG_W - 1);
            exp_q.push_back(e);
        end
        if (pc == IMG_W - 1) begin
            mc = 0;
            mr = (pr == IMG_H - 1) ? 0 : pr + 1;
        end else begin
            mc = pc + 1;
            mr = pr;
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBeats(int kind, int n, int gap_mode);
        int gap;
        for (int i = 0; i < n; i++) begin
            case (gap_mode)
                0:       gap = 0;
                1:       gap = 1;
                default: gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            endcase
            applyStimulus(kind, i == 0, gap);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        done_cyc = -1;
        mr = 0;
        mc = 0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_row !== 8'd0 ||
            out_col !== 8'd0 || frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state got v=%b d=%0d r=%0d c=%0d fd=%b want all zero",
                     out_valid, out_data, out_row, out_col, frame_done);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        bit exp_fd;
        exp_fd = (cyc == done_cyc);
        if (frame_done === 1'b1) fd_seen++;
        total++;
        if (frame_done !== exp_fd) begin
            bad++;
            $display("[TB] FAIL frame_done cyc=%0d got=%b want=%b", cyc, frame_done, exp_fd);
        end
        if (out_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_out cyc=%0d got d=%0d r=%0d c=%0d want none",
                         cyc, out_data, out_row, out_col);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_row !== e.row || out_col !== e.col || cyc != e.cyc) begin
                    bad++;
                    $display("[TB] FAIL median got d=%0d r=%0d c=%0d cyc=%0d want d=%0d r=%0d c=%0d cyc=%0d",
                             out_data, out_row, out_col, cyc, e.data, e.row, e.col, e.cyc);
                end
                if (e.last) done_cyc = cyc + 1;
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("[TB] FAIL missing_out cyc=%0d got out_valid=%b want d=%0d r=%0d c=%0d",
                     cyc, out_valid, e.data, e.row, e.col);
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        doReset();

        sendBeats(0, IMG_W * IMG_H, 0);
        sendBeats(1, IMG_W * IMG_H, 0);
        sendBeats(2, IMG_W * IMG_H, 1);
        for (int f = 0; f < 3; f++) sendBeats(3, IMG_W * IMG_H, 2);

        // Reset lands at (2,1), and later with windows still in flight
        sendBeats(3, 11, 0);
        doReset();
        sendBeats(3, IMG_W * IMG_H, 0);
        sendBeats(3, 14, 0);
        doReset();

        // Start-of-frame at (1,3), then on a beat that would complete a window
        sendBeats(3, 8, 0);
        sendBeats(3, IMG_W * IMG_H, 2);
        sendBeats(3, 12, 0);
        sendBeats(3, IMG_W * IMG_H, 0);

        idle(10);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got pending=%0d want 0", exp_q.size());
        end
        total++;
        if (fd_seen != FULL_FRAMES) begin
            bad++;
            $display("[TB] FAIL frame_count got=%0d want=%0d", fd_seen, FULL_FRAMES);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
